// File: rtl/ahb_slave_if_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_if_if
//   Signal bundle between the AHB-Lite bus, the ahb_slave_if responder and
//   its backend (the future APB controller).
//
//   AHB side : Hwrite, Hreadyin, Htrans, Haddr, Hwdata  (to responder)
//              Hreadyout, Hresp, Hrdata                 (from responder)
//   Backend  : bk_valid, bk_write, bk_addr, bk_sel, bk_wdata (from responder)
//              bk_ready, bk_rdata                       (to responder)
//
//   slave  modport : the responder's view.
//   master modport : the environment's view (bus master plus backend).
// ----------------------------------------------------------------------------
interface ahb_slave_if_if;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic        bk_valid;
  logic        bk_write;
  logic [31:0] bk_addr;
  logic [2:0]  bk_sel;
  logic [31:0] bk_wdata;
  logic        bk_ready;
  logic [31:0] bk_rdata;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, bk_ready, bk_rdata,
    output Hreadyout, Hresp, Hrdata,
           bk_valid, bk_write, bk_addr, bk_sel, bk_wdata
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, bk_ready, bk_rdata,
    input  Hreadyout, Hresp, Hrdata,
           bk_valid, bk_write, bk_addr, bk_sel, bk_wdata
  );
endinterface

// File: rtl/ahb_slave_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_if
//   AHB-Lite responder on the AHB side of the AHB2APB bridge. Accepts
//   NONSEQ/SEQ transfers, decodes three peripheral regions under 0x8xxx_xxxx
//   and hands each mapped transfer to a valid/ready backend, inserting wait
//   states until the backend completes. Unmapped addresses and backend
//   timeouts get the two-cycle AHB ERROR response.
//
//   Ports:
//     Hclk   : clock, all state changes on the rising edge
//     Hreset : asynchronous, active-high reset
//     bus    : ahb_slave_if_if.slave (AHB signals plus backend handshake)
//
//   Parameters:
//     WAIT_TIMEOUT : BUSY cycles without bk_ready before ERROR; 0 = never
//     CNT_W        : wait counter width, 2**CNT_W > WAIT_TIMEOUT
// ----------------------------------------------------------------------------
module ahb_slave_if #(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input logic          Hclk,
  input logic          Hreset,
  ahb_slave_if_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_BUSY, S_DONE, S_ERR1, S_ERR2} state_t;

  localparam logic [1:0]       RESP_OKAY  = 2'b00;
  localparam logic [1:0]       RESP_ERROR = 2'b01;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(WAIT_TIMEOUT);
  localparam bit               TIMEOUT_EN = (WAIT_TIMEOUT != 0);

  state_t           state,   state_n;
  logic [CNT_W-1:0] cnt,     cnt_n;
  logic             ready_q, ready_n;
  logic [1:0]       resp_q,  resp_n;
  logic [31:0]      rdata_q, rdata_n;
  logic             valid_q, valid_n;
  logic             write_q, write_n;
  logic [31:0]      addr_q,  addr_n;
  logic [2:0]       sel_q,   sel_n;

  logic       accept;
  logic       mapped;
  logic [2:0] dec_sel;

  // Only IDLE, DONE and ERR2 drive Hreadyout high, so ready_q also gates
  // acceptance to those states.
  assign accept  = bus.Hreadyin && ready_q && bus.Htrans[1];
  assign mapped  = (bus.Haddr[31:28] == 4'h8) && (bus.Haddr[27:26] != 2'b11);
  assign dec_sel = 3'b001 << bus.Haddr[27:26];

  // NOTE: every variable gets a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready_n = ready_q;
    resp_n  = resp_q;
    rdata_n = rdata_q;
    valid_n = valid_q;
    write_n = write_q;
    addr_n  = addr_q;
    sel_n   = sel_q;

    case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        // No accept: zero-wait OKAY, back to IDLE.
        state_n = S_IDLE;
        ready_n = 1'b1;
        resp_n  = RESP_OKAY;
        if (accept) begin
          if (mapped) begin
            state_n = S_BUSY;
            cnt_n   = '0;
            valid_n = 1'b1;
            write_n = bus.Hwrite;
            addr_n  = bus.Haddr;
            sel_n   = dec_sel;
            ready_n = 1'b0;
          end else begin
            state_n = S_ERR1;
            resp_n  = RESP_ERROR;
            ready_n = 1'b0;
          end
        end
      end

      S_BUSY: begin
        cnt_n = cnt + 1'b1;
        // bk_ready is checked first so it wins over a coincident timeout.
        if (bus.bk_ready) begin
          state_n = S_DONE;
          valid_n = 1'b0;
          ready_n = 1'b1;
          resp_n  = RESP_OKAY;
          sel_n   = '0;
          if (!write_q) rdata_n = bus.bk_rdata;
        end else if (TIMEOUT_EN && (cnt_n == TIMEOUT_C)) begin
          state_n = S_ERR1;
          valid_n = 1'b0;
          ready_n = 1'b0;
          resp_n  = RESP_ERROR;
          sel_n   = '0;
        end
      end

      // First ERROR cycle holds the bus; the second releases it.
      S_ERR1: begin
        state_n = S_ERR2;
        resp_n  = RESP_ERROR;
        ready_n = 1'b1;
      end

      default: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
        resp_n  = RESP_OKAY;
        valid_n = 1'b0;
      end
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      resp_q  <= RESP_OKAY;
      rdata_q <= '0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= ready_n;
      resp_q  <= resp_n;
      rdata_q <= rdata_n;
      valid_q <= valid_n;
      write_q <= write_n;
      addr_q  <= addr_n;
      sel_q   <= sel_n;
    end
  end

  assign bus.Hreadyout = ready_q;
  assign bus.Hresp     = resp_q;
  assign bus.Hrdata    = rdata_q;
  assign bus.bk_valid  = valid_q;
  assign bus.bk_write  = write_q;
  assign bus.bk_addr   = addr_q;
  assign bus.bk_sel    = sel_q;
  // Write data passes straight through while a request is open.
  assign bus.bk_wdata  = valid_q ? bus.Hwdata : 32'h0;

endmodule

// File: tb/tb_ahb_slave_if.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_if
//   Scoreboard bench for ahb_slave_if. Each transfer pushes its expected
//   backend request and its expected AHB completion; two monitors sampling on
//   the falling edge pop and compare when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_ahb_slave_if;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam int         TMO      = 16;

  typedef struct {
    int          low;        // Hreadyout-low cycles of the data phase
    logic [1:0]  resp_low;   // Hresp in the last low cycle
    logic [1:0]  resp_done;  // Hresp in the completing cycle
    logic [31:0] rdata;      // Hrdata in the completing cycle
    bit          okay;
  } cpl_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  sel;
    logic [31:0] wdata;
    int          len;        // cycles bk_valid stays high
  } bk_t;

  logic Hclk;
  logic Hreset;
  ahb_slave_if_if bus ();

  ahb_slave_if #(.WAIT_TIMEOUT(TMO), .CNT_W(5)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  cpl_t cpl_q[$];
  bk_t  bk_q[$];
  logic [31:0] model_rdata = 32'h0;

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.Htrans = T_IDLE;
    repeat (n) tick();
  endtask

  // One transfer starting with its address phase in the current cycle.
  // ready_at: BUSY cycle (1-based) in which bk_ready goes high; 0 = never.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int ready_at, input logic [31:0] rd);
    logic [2:0] sel;
    bit   is_mapped;
    bit   tmo;
    cpl_t c;
    bk_t  b;
    int   cyc;
    case (addr[27:26])
      2'b00:   sel = 3'b001;
      2'b01:   sel = 3'b010;
      2'b10:   sel = 3'b100;
      default: sel = 3'b000;
    endcase
    is_mapped = (addr[31:28] == 4'h8) && (sel != 3'b000);
    tmo       = (ready_at < 1) || (ready_at > TMO);
    if (!is_mapped) begin
      c = '{low: 1, resp_low: 2'b01, resp_done: 2'b01, rdata: model_rdata, okay: 1'b0};
    end else if (tmo) begin
      c = '{low: TMO + 1, resp_low: 2'b01, resp_done: 2'b01, rdata: model_rdata, okay: 1'b0};
      b = '{write: wr, addr: addr, sel: sel, wdata: wd, len: TMO};
      bk_q.push_back(b);
    end else begin
      if (!wr) model_rdata = rd;
      c = '{low: ready_at, resp_low: 2'b00, resp_done: 2'b00, rdata: model_rdata, okay: 1'b1};
      b = '{write: wr, addr: addr, sel: sel, wdata: wd, len: ready_at};
      bk_q.push_back(b);
    end
    cpl_q.push_back(c);

    bus.Haddr    = addr;
    bus.Hwrite   = wr;
    bus.Htrans   = T_NONSEQ;
    bus.Hreadyin = 1'b1;
    tick();
    bus.Htrans = T_IDLE;
    bus.Hwdata = wd;
    check("accept_bk_valid", 32'(bus.bk_valid), 32'(is_mapped));
    cyc = 0;
    while (bus.Hreadyout !== 1'b1 && cyc < 64) begin
      cyc++;
      bus.bk_ready = (ready_at != 0) && (cyc >= ready_at);
      bus.bk_rdata = bus.bk_ready ? rd : $urandom;
      tick();
    end
    bus.bk_ready = 1'b0;
    if (cyc >= 64) check("data_phase_bound", 32'(cyc), 32'd63);
  endtask

  // Completion monitor: measures each run of wait states.
  initial begin
    int         low_cnt;
    logic [1:0] last_resp;
    cpl_t       e;
    low_cnt = 0;
    last_resp = 2'b00;
    forever begin
      @(negedge Hclk);
      if (bus.Hreadyout === 1'b0) begin
        low_cnt++;
        last_resp = bus.Hresp;
      end else if (low_cnt > 0) begin
        if (cpl_q.size() == 0) begin
          check("cpl_unexpected", 32'd1, 32'd0);
        end else begin
          e = cpl_q.pop_front();
          check("low_cycles", 32'(low_cnt), 32'(e.low));
          check("resp_last_wait", 32'(last_resp), 32'(e.resp_low));
          check("resp_done", 32'(bus.Hresp), 32'(e.resp_done));
          check("hrdata", bus.Hrdata, e.rdata);
          check("bk_wdata_idle", bus.bk_wdata, 32'h0);
          if (e.okay) check("bk_sel_cleared", 32'(bus.bk_sel), 32'h0);
        end
        low_cnt = 0;
      end
    end
  end

  // Backend monitor: captures each request when bk_valid rises.
  initial begin
    logic prev;
    int   len;
    bk_t  got;
    bk_t  e;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(negedge Hclk);
      if (bus.bk_valid === 1'b1) begin
        if (!prev) begin
          got = '{write: bus.bk_write, addr: bus.bk_addr, sel: bus.bk_sel,
                  wdata: bus.bk_wdata, len: 0};
          len = 0;
        end
        len++;
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
        if (bk_q.size() == 0) begin
          check("bk_spurious", 32'd1, 32'd0);
        end else begin
          e = bk_q.pop_front();
          check("bk_write", 32'(got.write), 32'(e.write));
          check("bk_addr", got.addr, e.addr);
          check("bk_sel", 32'(got.sel), 32'(e.sel));
          check("bk_wdata", got.wdata, e.wdata);
          check("bk_valid_len", 32'(len), 32'(e.len));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Hreset       = 1'b1;
    bus.Hwrite   = 1'b0;
    bus.Hreadyin = 1'b1;
    bus.Htrans   = T_IDLE;
    bus.Haddr    = 32'h0;
    bus.Hwdata   = 32'h0;
    bus.bk_ready = 1'b0;
    bus.bk_rdata = 32'h0;
    repeat (2) tick();

    check("rst_hreadyout", 32'(bus.Hreadyout), 32'd1);
    check("rst_hresp", 32'(bus.Hresp), 32'd0);
    check("rst_hrdata", bus.Hrdata, 32'h0);
    check("rst_bk_valid", 32'(bus.bk_valid), 32'd0);
    check("rst_bk_write", 32'(bus.bk_write), 32'd0);
    check("rst_bk_addr", bus.bk_addr, 32'h0);
    check("rst_bk_sel", 32'(bus.bk_sel), 32'd0);
    check("rst_bk_wdata", bus.bk_wdata, 32'h0);
    Hreset = 1'b0;
    idle(2);

    // Single write, single read, then a write that must not disturb Hrdata.
    xfer(32'h8000_0001, 1'b1, 32'h0000_00A3, 1, 32'h0);
    idle(2);
    xfer(32'h8000_00A2, 1'b0, 32'h0000_0011, 3, 32'h1234_5678);
    idle(1);
    xfer(32'h8000_0004, 1'b1, 32'h0000_0055, 2, 32'h0);
    idle(2);

    // Back-to-back: the read is presented during the write's DONE cycle.
    xfer(32'h8400_0010, 1'b1, 32'h0000_0BEE, 1, 32'h0);
    xfer(32'h8800_0020, 1'b0, 32'h0000_0000, 2, 32'hCAFE_F00D);
    idle(2);

    // Unmapped region 3 and unmapped top nibble; bk_ready in ERR1 is ignored.
    xfer(32'h8C00_0000, 1'b0, 32'h0, 1, 32'hFFFF_FFFF);
    xfer(32'h0000_0000, 1'b1, 32'h7, 1, 32'h0);
    tick();
    check("post_err_hresp", 32'(bus.Hresp), 32'd0);
    check("post_err_hreadyout", 32'(bus.Hreadyout), 32'd1);
    idle(2);

    // Timeout, then bk_ready arriving exactly on the timeout cycle.
    xfer(32'h8000_0100, 1'b0, 32'h0, 0, 32'h0);
    xfer(32'h8800_0008, 1'b0, 32'h0, TMO, 32'hDEAD_BEEF);
    idle(2);

    // IDLE/BUSY transfer types and Hreadyin=0 are never accepted.
    bus.Haddr  = 32'h8000_0000;
    bus.Htrans = T_BUSY;
    repeat (2) begin
      tick();
      check("busy_no_valid", 32'(bus.bk_valid), 32'd0);
      check("busy_ready", 32'(bus.Hreadyout), 32'd1);
    end
    bus.Htrans   = T_NONSEQ;
    bus.Hreadyin = 1'b0;
    repeat (2) begin
      tick();
      check("nrdy_no_valid", 32'(bus.bk_valid), 32'd0);
      check("nrdy_hresp", 32'(bus.Hresp), 32'd0);
    end
    bus.Hreadyin = 1'b1;
    idle(1);

    // Reset while BUSY: outputs must clear before the next rising edge.
    bk_q.push_back('{write: 1'b1, addr: 32'h8000_0044, sel: 3'b001, wdata: 32'h99, len: 1});
    model_rdata = 32'h0;
    cpl_q.push_back('{low: 1, resp_low: 2'b00, resp_done: 2'b00, rdata: 32'h0, okay: 1'b1});
    bus.Haddr  = 32'h8000_0044;
    bus.Hwrite = 1'b1;
    bus.Htrans = T_NONSEQ;
    tick();
    bus.Htrans = T_IDLE;
    bus.Hwdata = 32'h99;
    check("rst_mid_accept", 32'(bus.bk_valid), 32'd1);
    #5;
    Hreset = 1'b1;
    #1;
    check("rst_mid_bk_valid", 32'(bus.bk_valid), 32'd0);
    check("rst_mid_hreadyout", 32'(bus.Hreadyout), 32'd1);
    #1;
    Hreset = 1'b0;
    tick();

    // Recovery after reset.
    xfer(32'h8400_0000, 1'b0, 32'h0, 2, 32'h0BAD_CAFE);
    idle(3);

    check("cpl_queue_drained", 32'(cpl_q.size()), 32'd0);
    check("bk_queue_drained", 32'(bk_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
